// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/response bus between the fetch unit and memory.
//   imem_req    : fetch request valid (master -> slave)
//   imem_addr   : word-aligned fetch address (master -> slave)
//   imem_gnt    : request accepted when imem_req && imem_gnt (slave -> master)
//   imem_rvalid : in-order response valid, >= 1 cycle after grant (slave -> master)
//   imem_rdata  : response instruction word (slave -> master)
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage: issues word fetches to instruction memory, keeps a
// 2-entry in-order buffer of {instr, pc} for decode, and discards responses
// that were in flight when a redirect arrived.
// Ports:
//   clk, reset       : single clock, synchronous active-high reset
//   stall            : decode does not accept an instruction this cycle
//   redirect         : taken branch/jump, overrides everything else
//   redirect_pc      : new fetch address (bits [1:0] ignored)
//   imem             : instruction-memory bus (master side)
//   IF_instr/IF_pc   : head instruction and its address
//   IF_valid         : IF_instr/IF_pc are valid
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    if_fetch_unit_if.master         imem,
    output logic [31:0]             IF_instr,
    output logic [31:0]             IF_pc,
    output logic                    IF_valid
);

    localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Fetch control state
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  out_q, out_d;        // requests granted but not yet answered
    logic [1:0]  stale_q, stale_d;    // of those, how many to throw away

    // Decode-side buffer
    logic [DEPTH-1:0][31:0] buf_instr_q, buf_instr_d;
    logic [DEPTH-1:0][31:0] buf_pc_q, buf_pc_d;
    logic                   buf_wr_q, buf_wr_d;
    logic                   buf_rd_q, buf_rd_d;
    logic [1:0]             buf_cnt_q, buf_cnt_d;
    logic [31:0]            last_pc_q, last_pc_d;

    // PCs of live (non-stale) requests, in grant order
    logic [DEPTH-1:0][31:0] lpc_q, lpc_d;
    logic                   lpc_wr_q, lpc_wr_d;
    logic                   lpc_rd_q, lpc_rd_d;

    logic        buf_valid;
    logic        pop;
    logic        req;
    logic        grant;
    logic        rsp;
    logic        live_rsp;
    logic [2:0]  credit;

    assign buf_valid = (buf_cnt_q != 2'd0);
    assign pop       = buf_valid && !stall && !redirect;

    // Slots already claimed: in flight plus buffered entries that survive
    // this cycle's pop. Counting the pop lets a steady stream run without
    // bubbles while still guaranteeing every response finds a free slot.
    assign credit    = {1'b0, out_q} + {1'b0, buf_cnt_q} - {2'b00, pop};
    assign req       = !reset && !redirect && (credit < 3'd2);
    assign grant     = req && imem.imem_gnt;
    assign rsp       = imem.imem_rvalid;
    assign live_rsp  = rsp && !redirect && (state_q == RUN);

    // Per-entry write data for the buffer and the live-PC queue
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign buf_instr_d[gi] = (live_rsp && buf_wr_q == 1'(gi)) ? imem.imem_rdata
                                                                   : buf_instr_q[gi];
        assign buf_pc_d[gi]    = (live_rsp && buf_wr_q == 1'(gi)) ? lpc_q[lpc_rd_q]
                                                                   : buf_pc_q[gi];
        assign lpc_d[gi]       = (grant && lpc_wr_q == 1'(gi)) ? pc_q : lpc_q[gi];
    end

    always_comb begin
        pc_d      = pc_q;
        out_d     = out_q;
        stale_d   = stale_q;
        state_d   = state_q;
        buf_wr_d  = buf_wr_q;
        buf_rd_d  = buf_rd_q;
        buf_cnt_d = buf_cnt_q;
        lpc_wr_d  = lpc_wr_q;
        lpc_rd_d  = lpc_rd_q;
        last_pc_d = buf_valid ? buf_pc_q[buf_rd_q] : last_pc_q;

        case ({grant, rsp})
            2'b10:   out_d = out_q + 2'd1;
            2'b01:   out_d = out_q - 2'd1;
            default: out_d = out_q;
        endcase

        if (grant) begin
            pc_d = pc_q + 32'd4;
        end

        if (redirect) begin
            pc_d      = redirect_pc & 32'hFFFF_FFFC;
            // A response landing this very cycle is already gone.
            stale_d   = out_q - {1'b0, rsp};
            state_d   = (stale_d != 2'd0) ? FLUSH : RUN;
            buf_wr_d  = 1'b0;
            buf_rd_d  = 1'b0;
            buf_cnt_d = 2'd0;
            lpc_wr_d  = 1'b0;
            lpc_rd_d  = 1'b0;
        end else begin
            if (state_q == FLUSH && rsp) begin
                stale_d = stale_q - 2'd1;
                if (stale_q == 2'd1) begin
                    state_d = RUN;
                end
            end

            if (live_rsp) begin
                buf_wr_d = buf_wr_q + 1'b1;
                lpc_rd_d = lpc_rd_q + 1'b1;
            end
            if (pop) begin
                buf_rd_d = buf_rd_q + 1'b1;
            end
            if (grant) begin
                lpc_wr_d = lpc_wr_q + 1'b1;
            end

            case ({live_rsp, pop})
                2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
                2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
                default: buf_cnt_d = buf_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC_A;
            out_q       <= 2'd0;
            stale_q     <= 2'd0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            buf_wr_q    <= 1'b0;
            buf_rd_q    <= 1'b0;
            buf_cnt_q   <= 2'd0;
            last_pc_q   <= RESET_PC_A;
            lpc_q       <= '0;
            lpc_wr_q    <= 1'b0;
            lpc_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_q       <= out_d;
            stale_q     <= stale_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            buf_wr_q    <= buf_wr_d;
            buf_rd_q    <= buf_rd_d;
            buf_cnt_q   <= buf_cnt_d;
            last_pc_q   <= last_pc_d;
            lpc_q       <= lpc_d;
            lpc_wr_q    <= lpc_wr_d;
            lpc_rd_q    <= lpc_rd_d;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;

    // Decode outputs are forced to their idle values for as long as reset
    // is held, not just from the first reset edge onward.
    assign IF_valid = !reset && buf_valid;
    assign IF_instr = IF_valid ? buf_instr_q[buf_rd_q] : 32'h0000_0000;
    assign IF_pc    = reset     ? RESET_PC_A :
                      buf_valid ? buf_pc_q[buf_rd_q] : last_pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] IF_instr, IF_pc;
    logic        IF_valid;

    always #5 clk = ~clk;

    if_fetch_unit_if bus();

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .IF_instr    (IF_instr),
        .IF_pc       (IF_pc),
        .IF_valid    (IF_valid)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // memory side: every granted request (live or stale), in order
    typedef struct { logic [31:0] pc; int gcyc; } mem_t;
    mem_t mem_q[$];
    // scoreboard: expected buffer contents seen by decode
    typedef struct { logic [31:0] pc; logic [31:0] instr; } sb_t;
    sb_t sb_q[$];
    logic [31:0] live_q[$];

    logic [31:0] m_pc, m_last_pc;
    int          m_out, m_stale;
    logic        prev_reset = 1'b0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, sample at negedge, check, advance model.
    task automatic step(input logic r, input logic st, input logic rd,
                        input logic [31:0] rp, input logic g, input logic re);
        logic m_req, grant, rsp, m_valid, pop;
        logic [31:0] lpc;
        int used;
        reset       = r;
        stall       = st;
        redirect    = rd;
        redirect_pc = rp;
        bus.imem_gnt = g;
        rsp = re && (mem_q.size() > 0) && (mem_q[0].gcyc < cyc);
        bus.imem_rvalid = rsp;
        bus.imem_rdata  = rsp ? mem_fn(mem_q[0].pc) : 32'hDEAD_BEEF;
        @(negedge clk);
        s_req = bus.imem_req; s_addr = bus.imem_addr;
        s_valid = IF_valid; s_pc = IF_pc; s_instr = IF_instr;
        if (r) begin
            chk("rst_req", {31'b0, s_req}, 32'd0);
            chk("rst_valid", {31'b0, s_valid}, 32'd0);
            chk("rst_instr", s_instr, 32'd0);
            chk("rst_pc", s_pc, RESET_PC);
            if (prev_reset) chk("rst_addr", s_addr, RESET_PC);
            mem_q.delete(); sb_q.delete(); live_q.delete();
            m_pc = RESET_PC; m_last_pc = RESET_PC; m_out = 0; m_stale = 0;
        end else begin
            m_valid = (sb_q.size() != 0);
            pop     = m_valid && !st && !rd;
            used    = m_out + sb_q.size() - (pop ? 1 : 0);
            m_req   = !rd && (used < 2);
            chk("req", {31'b0, s_req}, {31'b0, m_req});
            if (m_req) chk("addr", s_addr, m_pc);
            chk("valid", {31'b0, s_valid}, {31'b0, m_valid});
            if (m_valid) begin
                chk("if_pc", s_pc, sb_q[0].pc);
                chk("if_instr", s_instr, sb_q[0].instr);
                m_last_pc = sb_q[0].pc;
            end else begin
                chk("if_pc_hold", s_pc, m_last_pc);
                chk("if_nop", s_instr, 32'd0);
            end
            grant = m_req && g;
            if (rsp) void'(mem_q.pop_front());
            if (grant) mem_q.push_back('{m_pc, cyc});
            if (rd) begin
                sb_q.delete(); live_q.delete();
                m_stale = m_out - (rsp ? 1 : 0);
                m_pc = rp & 32'hFFFF_FFFC;
            end else begin
                if (pop) void'(sb_q.pop_front());
                if (rsp) begin
                    if (m_stale > 0) m_stale--;
                    else if (live_q.size() > 0) begin
                        lpc = live_q.pop_front();
                        sb_q.push_back('{lpc, mem_fn(lpc)});
                    end
                end
                if (grant) begin
                    live_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
            m_out = m_out + (grant ? 1 : 0) - (rsp ? 1 : 0);
        end
        $display("[TB] cyc=%0d rst=%b st=%b rd=%b g=%b rv=%b req=%b addr=%h valid=%b pc=%h instr=%h",
                 cyc, r, st, rd, g, rsp, s_req, s_addr, s_valid, s_pc, s_instr);
        prev_reset = r;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic        rst, st, rd;
        logic [31:0] rp;
        logic        g, re;
        logic        exp_req, exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[12];

    initial begin : main
        logic        found;
        logic        prev_fffc;
        logic [31:0] h_instr;

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
        #1;

        // reset, then a continuous stream: gnt every cycle, rvalid 1 cycle later
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0};
        for (int i = 4; i < 12; i++)
            vecs[i] = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'((i - 4) * 4)};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].rd, vecs[i].rp, vecs[i].g, vecs[i].re);
            chk("vec_req", {31'b0, s_req}, {31'b0, vecs[i].exp_req});
            chk("vec_valid", {31'b0, s_valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) chk("vec_pc", s_pc, vecs[i].exp_pc);
        end

        // full buffer under stall: request drops, head held, then drains in order
        h_instr = 32'd0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
            if (k == 0) h_instr = s_instr;
            chk("stall_hold_instr", s_instr, h_instr);
            chk("stall_hold_pc", s_pc, 32'h20);
        end
        chk("full_req", {31'b0, s_req}, 32'd0);
        chk("full_valid", {31'b0, s_valid}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("drain0_pc", s_pc, 32'h20);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("drain1_pc", s_pc, 32'h24);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("drain2_valid", {31'b0, s_valid}, 32'd0);

        // two outstanding, redirect to 0x100: both old responses dropped
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
        chk("redir_req_low", {31'b0, s_req}, 32'd0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
            found = s_valid;
        end
        chk("redir_found", {31'b0, found}, 32'd1);
        chk("redir_first_pc", s_pc, 32'h100);

        // drain, two outstanding, redirect+stall with one response arriving
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
            found = s_valid;
        end
        chk("rs_found", {31'b0, found}, 32'd1);
        chk("rs_first_pc", s_pc, 32'h200);

        // wrap: redirect to 0xFFFFFFFF (aligned down), next fetch after top is 0
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        found = 1'b0; prev_fffc = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
            if (prev_fffc && s_req) begin
                chk("wrap_addr", s_addr, 32'h0000_0000);
                found = 1'b1;
            end
            prev_fffc = s_req && (s_addr == 32'hFFFF_FFFC);
        end
        chk("wrap_found", {31'b0, found}, 32'd1);

        // reset in the middle of a flush
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h400, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("post_rst_req", {31'b0, s_req}, 32'd1);
        chk("post_rst_addr", s_addr, RESET_PC);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
            found = s_valid;
        end
        chk("post_rst_found", {31'b0, found}, 32'd1);
        chk("post_rst_pc", s_pc, RESET_PC);

        // random traffic against the scoreboard
        for (int k = 0; k < 300; k++) begin
            step(1'b0,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 15) == 0),
                 $urandom,
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
